// File: rtl/operand_loader_pkg.sv
// Shared types and constants for the operand loader: FSM phase encoding
// and the default debounce interval (5 ms at 50 MHz).
package operand_loader_pkg;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 250000;

  // Phase values double as the indicator LED encoding; 2'd3 is unused/illegal.
  typedef enum logic [1:0] {
    WAIT_A = 2'd0,
    WAIT_B = 2'd1,
    SHOW   = 2'd2
  } phase_t;

endpackage

// File: rtl/operand_loader_debouncer.sv
// Button conditioner: synchronizer chain, consecutive-cycle debounce
// counter with an accepted stable level, and a one-cycle pulse on each
// rising edge of the stable level.
module operand_loader_debouncer
  import operand_loader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   synced;
  logic                   stable;
  logic                   stable_d;
  logic [CNT_W-1:0]       count;

  assign synced = sync[SYNC_STAGES-1];

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
    end else begin
      sync[0] <= raw;
      for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
    end
  end

  // Accept a new level only after it differs from the stable one for
  // DEBOUNCE_CYCLES consecutive cycles; any return to the stable level restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= 1'b0;
      count  <= '0;
    end else if (synced == stable) begin
      count <= '0;
    end else if (count == CNT_LAST) begin
      stable <= ~stable;
      count  <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  // Registered single-cycle pulse on a rising stable level only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_d <= 1'b0;
      pulse    <= 1'b0;
    end else begin
      stable_d <= stable;
      pulse    <= stable & ~stable_d;
    end
  end

endmodule

// File: rtl/operand_loader.sv
// Two-operand entry from switches: a load button captures A then B, a
// clear button restarts entry. Outputs feed the adder/BCD display stage.
module operand_loader
  import operand_loader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw,
  input  logic       btn_load,
  input  logic       btn_clear,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic       operands_valid,
  output logic [1:0] phase
);

  logic [3:0] sw_sync [SYNC_STAGES];
  logic [3:0] sw_synced;
  logic       load_p;
  logic       clear_p;
  phase_t     state;

  assign sw_synced = sw_sync[SYNC_STAGES-1];
  assign phase     = state;

  // Synchronize the operand switches with the same depth as the buttons.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sw_sync[i] <= '0;
    end else begin
      sw_sync[0] <= sw;
      for (int i = 1; i < SYNC_STAGES; i++) sw_sync[i] <= sw_sync[i-1];
    end
  end

  operand_loader_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_load_debouncer (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (btn_load),
    .pulse(load_p)
  );

  operand_loader_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_clear_debouncer (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (btn_clear),
    .pulse(clear_p)
  );

  // Entry FSM; clear wins over load, and a load in SHOW starts a new entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      A              <= '0;
      B              <= '0;
      operands_valid <= 1'b0;
      state          <= WAIT_A;
    end else if (clear_p) begin
      A              <= '0;
      B              <= '0;
      operands_valid <= 1'b0;
      state          <= WAIT_A;
    end else begin
      case (state)
        WAIT_A: begin
          if (load_p) begin
            A     <= sw_synced;
            state <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (load_p) begin
            B              <= sw_synced;
            operands_valid <= 1'b1;
            state          <= SHOW;
          end
        end
        SHOW: begin
          if (load_p) begin
            A              <= sw_synced;
            operands_valid <= 1'b0;
            state          <= WAIT_B;
          end
        end
        default: begin
          A              <= '0;
          B              <= '0;
          operands_valid <= 1'b0;
          state          <= WAIT_A;
        end
      endcase
    end
  end

endmodule
